uart_rx_param: RTL and testbench

Parametrised UART receiver and the next generation of the fixed 8N1 receiver used in front of the packer and AXI/DDR write path. It adds configurable data width, optional odd/even parity, 1 or 2 stop bits, and an input synchronizer. It also adds false-start rejection, parity/framing error reporting and back-to-back frame reception without idle gaps. Its output feeds the byte packer: one `done` pulse per frame with `result` and error flags.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 39 +++
 rtl/uart_rx_param.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver family: parity mode codes,
// receiver state encoding and the bit-period helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Clocks per bit, truncated; callers require the result to be >= 8.
    function automatic int bit_clks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous idle-high serial line, with a
// registered falling-edge strobe taken from the synchronized level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   fall_q, fall_d;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = fall_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
        prev_d = rx_s;
        fall_d = prev_q & ~rx_s;
    end

    // Everything resets to the idle level so reset itself never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fall_q <= fall_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, parity and stop bits, with
// false-start rejection and per-frame parity/framing error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int BIT_T = bit_clks(CLK_FREQ, BAUD_RATE);
    localparam int CW    = $clog2(BIT_T + 1);
    localparam int IW    = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] T_LAST    = CW'(BIT_T - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_T / 2 - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  perr_pend_q, perr_pend_d;
    logic                  ferr_pend_q, ferr_pend_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  done_q, done_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  par_exp;

    assign result     = result_q;
    assign done       = done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != RX_IDLE);

    always_comb begin
        par_exp      = (PARITY_MODE == PARITY_ODD) ? ~^shift_q : ^shift_q;
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        perr_pend_d  = perr_pend_q;
        ferr_pend_d  = ferr_pend_q;
        result_d     = result_q;
        done_d       = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d     = RX_START;
                    idx_d       = '0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                // Shifting in from the top leaves the first (LSB) bit at index 0.
                if (cnt_q == T_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (cnt_q == T_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_STOP;
                    if (rx_s != par_exp) begin
                        perr_pend_d = 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == T_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_pend_d = 1'b1;
                    end
                    // Return to IDLE straight after the last mid-sample so a
                    // start bit that immediately follows is not missed.
                    if (idx_q == STOP_LAST) begin
                        idx_d        = '0;
                        state_d      = RX_IDLE;
                        done_d       = 1'b1;
                        result_d     = shift_q;
                        parity_err_d = perr_pend_q;
                        frame_err_d  = ferr_pend_q | ~rx_s;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            perr_pend_q  <= 1'b0;
            ferr_pend_q  <= 1'b0;
            result_q     <= '0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            perr_pend_q  <= perr_pend_d;
            ferr_pend_q  <= ferr_pend_d;
            result_q     <= result_d;
            done_q       <= done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an 8E1 instance,
// T = 10 clocks per bit, directed frames with hand-computed expectations.
module tb_uart_rx_param;

    localparam int T = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_n  = 1'b1;
    logic       rx_e  = 1'b1;
    logic [7:0] res_n, res_e;
    logic       done_n, done_e, pe_n, pe_e, fe_n, fe_e, busy_n, busy_e;

    exp_t q_n[$];
    exp_t q_e[$];
    int   done_cyc_n[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt_n = 0;
    int   done_cnt_e = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(
        .DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .rx(rx_n), .result(res_n), .done(done_n),
        .parity_err(pe_n), .frame_err(fe_n), .busy(busy_n)
    );

    uart_rx_param #(
        .DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .PARITY_MODE(2), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut_e (
        .clk(clk), .rst_n(rst_n), .rx(rx_e), .result(res_e), .done(done_e),
        .parity_err(pe_e), .frame_err(fe_e), .busy(busy_e)
    );

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a done pulse appears.
    always @(negedge clk) begin
        if (done_n) begin
            exp_t e;
            done_cnt_n++;
            done_cyc_n.push_back(cyc);
            if (q_n.size() == 0) begin
                total++;
                bad++;
                $display("FAIL n_unexpected_done: got result %0h with no frame expected", res_n);
            end else begin
                e = q_n.pop_front();
                $display("n frame: result=%0h pe=%0b fe=%0b (want %0h %0b %0b)",
                         res_n, pe_n, fe_n, e.data, e.pe, e.fe);
                check("n_result", res_n, e.data);
                check("n_parity_err", pe_n, e.pe);
                check("n_frame_err", fe_n, e.fe);
                check("n_busy_at_done", busy_n, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done_e) begin
            exp_t e;
            done_cnt_e++;
            if (q_e.size() == 0) begin
                total++;
                bad++;
                $display("FAIL e_unexpected_done: got result %0h with no frame expected", res_e);
            end else begin
                e = q_e.pop_front();
                $display("e frame: result=%0h pe=%0b fe=%0b (want %0h %0b %0b)",
                         res_e, pe_e, fe_e, e.data, e.pe, e.fe);
                check("e_result", res_e, e.data);
                check("e_parity_err", pe_e, e.pe);
                check("e_frame_err", fe_e, e.fe);
                check("e_busy_at_done", busy_e, 0);
            end
        end
    end

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) rx_e = v;
        else     rx_n = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                        input logic par, input logic stopv);
        drive(sel, 1'b0, T);
        for (int i = 0; i < 8; i++) drive(sel, d[i], T);
        if (has_par) drive(sel, par, T);
        drive(sel, stopv, T);
    endtask

    // Idle the line long enough for any pending done, then require the queue empty.
    task automatic drain(input bit sel, input string name);
        drive(sel, 1'b1, 3 * T);
        check(name, sel ? q_e.size() : q_n.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int gap;
        bit busy_seen;

        repeat (3) @(negedge clk);
        check("rst_result", res_n, 0);
        check("rst_done", done_n, 0);
        check("rst_parity_err", pe_n, 0);
        check("rst_frame_err", fe_n, 0);
        check("rst_busy", busy_n, 0);
        check("rst_busy_e", busy_e, 0);
        rst_n = 1'b1;
        repeat (2 * T) @(negedge clk);

        // 8N1 0xA5
        q_n.push_back(mk(8'hA5, 1'b0, 1'b0));
        send(0, 8'hA5, 0, 1'b0, 1'b1);
        drain(0, "a5_drained");
        check("a5_busy_after", busy_n, 0);
        check("a5_done_count", done_cnt_n, 1);

        // Even parity, 0x37 has five ones so the correct parity bit is 1
        q_e.push_back(mk(8'h37, 1'b1, 1'b0));
        send(1, 8'h37, 1, 1'b0, 1'b1);
        drain(1, "par_bad_drained");
        q_e.push_back(mk(8'h37, 1'b0, 1'b0));
        send(1, 8'h37, 1, 1'b1, 1'b1);
        drain(1, "par_good_drained");

        // Framing error, line held low afterwards must not retrigger
        q_n.push_back(mk(8'h3C, 1'b0, 1'b1));
        send(0, 8'h3C, 0, 1'b0, 1'b0);
        drive(0, 1'b0, 5 * T);
        drain(0, "fe_drained");
        q_n.push_back(mk(8'h11, 1'b0, 1'b0));
        send(0, 8'h11, 0, 1'b0, 1'b1);
        drain(0, "after_fe_drained");

        // Short glitch: false start
        dc = done_cnt_n;
        busy_seen = 0;
        rx_n = 1'b0;
        repeat (3) @(negedge clk);
        rx_n = 1'b1;
        for (int i = 0; i < 3 * T; i++) begin
            @(negedge clk);
            if (busy_n) busy_seen = 1;
        end
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_after", busy_n, 0);
        check("glitch_no_done", done_cnt_n, dc);
        check("glitch_result_kept", res_n, 8'h11);
        check("glitch_fe_kept", fe_n, 0);

        // Back-to-back frames with no idle gap
        q_n.push_back(mk(8'h00, 1'b0, 1'b0));
        q_n.push_back(mk(8'hFF, 1'b0, 1'b0));
        send(0, 8'h00, 0, 1'b0, 1'b1);
        send(0, 8'hFF, 0, 1'b0, 1'b1);
        drain(0, "b2b_drained");
        if (done_cyc_n.size() >= 2) begin
            gap = done_cyc_n[done_cyc_n.size()-1] - done_cyc_n[done_cyc_n.size()-2];
            check("b2b_gap_about_100", (gap >= 99 && gap <= 101), 1);
        end else begin
            check("b2b_done_stamps", done_cyc_n.size(), 2);
        end

        // Reset during data bit 3 of 0x96; sender aborts
        drive(0, 1'b0, T);
        for (int i = 0; i < 3; i++) drive(0, i[0] ? 1'b1 : (i == 2 ? 1'b1 : 1'b0), T);
        drive(0, 1'b0, 5);
        dc = done_cnt_n;
        rst_n = 1'b0;
        rx_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_result", res_n, 0);
        check("midrst_done", done_n, 0);
        check("midrst_parity_err", pe_n, 0);
        check("midrst_frame_err", fe_n, 0);
        check("midrst_busy", busy_n, 0);
        repeat (20 * T) @(negedge clk);
        check("midrst_no_done", done_cnt_n, dc);
        q_n.push_back(mk(8'h5A, 1'b0, 1'b0));
        send(0, 8'h5A, 0, 1'b0, 1'b1);
        drain(0, "5a_drained");

        check("total_done_n", done_cnt_n, 6);
        check("total_done_e", done_cnt_e, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
